bip_control_unit: RTL and testbench

Instruction sequencer for the accumulator datapath. It fetches 16-bit instructions (5-bit opcode, 11-bit operand) from program memory and drives the datapath controls (SelA, SelB, WrAcc, Op, Clear) plus data-memory strobes. It holds the PC and a run-cycle counter, and it accepts a Start pulse and reports Busy/Halted. It sits between the program memory, data memory and datapath inside the processor top level.

---
 rtl/bip_control_unit.sv | 76 +++++++
 tb/tb_bip_control_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bip_control_unit.sv
// bip_control_unit: instruction sequencer for the accumulator datapath (fetch/exec/mem FSM, PC, run-cycle counter).
module bip_control_unit #(
  parameter int PC_W  = 11,
  parameter int OP_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [OP_W+PC_W-1:0] Instr,
  output logic [PC_W-1:0]      Prog_Addr,
  output logic                 Rd_Prog,
  output logic [PC_W-1:0]      Addr,
  output logic                 Rd,
  output logic                 Wr,
  output logic [1:0]           SelA,
  output logic                 SelB,
  output logic                 WrAcc,
  output logic                 Op,
  output logic                 Clear,
  output logic                 Busy,
  output logic                 Halted,
  output logic [CNT_W-1:0]     Clk_Count
);
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;
  localparam logic [OP_W-1:0] HLT = 0, STO = 1, LD = 2, LDI = 3, ADD = 4, ADDI = 5, SUB = 6, SUBI = 7;
  state_t state, st;
  logic [OP_W+PC_W-1:0] ir;
  logic [PC_W-1:0] pc;
  logic [OP_W-1:0] op_x, op_m;
  logic mem_op;
  assign op_x = Instr[OP_W+PC_W-1:PC_W];
  assign op_m = ir[OP_W+PC_W-1:PC_W];
  assign mem_op = op_x inside {LD, ADD, SUB};
  // a low Reset forces idle outputs immediately so an in-flight write is suppressed
  assign st = Reset ? state : IDLE;
  always_ff @(posedge clk)
    if (!Reset) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      Clk_Count <= '0;
    end else begin
      if (state inside {FETCH, EXEC, MEM} && !(&Clk_Count)) Clk_Count <= Clk_Count + 1'b1;
      case (state)
        IDLE, HALT: if (Start) begin
          state <= FETCH;
          pc <= '0;
          Clk_Count <= '0;
        end
        FETCH: state <= EXEC;
        EXEC: begin
          ir <= Instr;
          state <= op_x == HLT ? HALT : mem_op ? MEM : FETCH;
          if (op_x != HLT && !mem_op) pc <= pc + 1'b1;
        end
        MEM: begin
          state <= FETCH;
          pc <= pc + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  assign Prog_Addr = pc;
  assign Rd_Prog   = st == FETCH;
  assign Addr      = st == EXEC ? Instr[PC_W-1:0] : ir[PC_W-1:0];
  assign Rd        = st == EXEC && mem_op;
  assign Wr        = st == EXEC && op_x == STO;
  assign WrAcc     = (st == EXEC && op_x inside {LDI, ADDI, SUBI}) || st == MEM;
  assign SelA      = st == EXEC && op_x == LDI ? 2'b01 : st == MEM && op_m == LD ? 2'b10 : 2'b00;
  assign SelB      = st == MEM && op_m inside {ADD, SUB};
  assign Op        = !((st == EXEC && op_x == SUBI) || (st == MEM && op_m == SUB));
  assign Clear     = st == IDLE || (st == HALT && Start);
  assign Busy      = st inside {FETCH, EXEC, MEM};
  assign Halted    = st == HALT;
endmodule

// File: tb/tb_bip_control_unit.sv
// tb_bip_control_unit: directed bench with program/data memory and accumulator models around the sequencer.
module tb_bip_control_unit;
  logic clk = 0, Reset = 0, Start = 0;
  logic [15:0] instr;
  logic [10:0] Prog_Addr, Addr;
  logic Rd_Prog, Rd, Wr, SelB, WrAcc, Op, Clear, Busy, Halted;
  logic [1:0] SelA;
  logic [15:0] Clk_Count;
  logic [15:0] prog [2048];
  logic [15:0] dmem [2048];
  logic [15:0] mem_q, acc, imm, b;
  int checks = 0, errors = 0, wr_n;

  bip_control_unit dut (.clk(clk), .Reset(Reset), .Start(Start), .Instr(instr), .Prog_Addr(Prog_Addr),
    .Rd_Prog(Rd_Prog), .Addr(Addr), .Rd(Rd), .Wr(Wr), .SelA(SelA), .SelB(SelB), .WrAcc(WrAcc), .Op(Op),
    .Clear(Clear), .Busy(Busy), .Halted(Halted), .Clk_Count(Clk_Count));

  always #5 clk = ~clk;
  assign imm = {{5{Addr[10]}}, Addr};
  assign b = SelB ? mem_q : imm;
  always @(posedge clk) begin
    if (Rd_Prog) instr <= prog[Prog_Addr];
    if (!Reset) dmem[4] <= 16'd10;
    if (Rd) mem_q <= dmem[Addr];
    if (Wr) dmem[Addr] <= acc;
    if (Clear) acc <= 16'd0;
    else if (WrAcc) acc <= SelA == 2'b01 ? imm : SelA == 2'b10 ? mem_q : Op ? acc + b : acc - b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_halt(input string tag);
    int n = 0;
    while (!Halted && n < 50) begin
      step();
      n++;
    end
    check(tag, Halted, 1);
  endtask

  initial begin
    // 1: reset and idle
    step();
    step();
    Reset = 1;
    step();
    check("t1_clear", Clear, 1);
    check("t1_busy", {Busy, Halted}, 0);
    check("t1_pc", Prog_Addr, 0);
    check("t1_strobes", {Rd_Prog, Rd, Wr, WrAcc}, 0);
    check("t1_cnt", Clk_Count, 0);
    step();
    check("t1_hold", {Clear, Busy}, 2'b10);
    // 2: LDI 5; ADDI 3; SUBI 1; HLT
    prog[0] = {5'd3, 11'd5};
    prog[1] = {5'd5, 11'd3};
    prog[2] = {5'd7, 11'd1};
    prog[3] = 16'd0;
    Start = 1;
    step();
    Start = 0;
    wr_n = 0;
    for (int c = 1; c <= 8; c++) begin
      check("t2_busy", Busy, 1);
      check("t2_cnt", Clk_Count, c - 1);
      check("t2_pc", Prog_Addr, (c - 1) / 2);
      if (c == 2) check("t2_ldi", {WrAcc, SelA}, 3'b101);
      if (c == 4) check("t2_addi", {WrAcc, SelA, SelB, Op}, 5'b10001);
      if (c == 6) check("t2_subi", {WrAcc, SelA, SelB, Op}, 5'b10000);
      check("t2_excl", {Rd, Wr}, 0);
      wr_n += int'(WrAcc);
      step();
    end
    check("t2_wracc_n", wr_n, 3);
    check("t2_halted", {Halted, Busy, Clear}, 3'b100);
    check("t2_cnt_end", Clk_Count, 8);
    check("t2_acc", acc, 7);
    // 6: restart from HALT, Start held while busy
    step();
    check("t6_acc_kept", acc, 7);
    Start = 1;
    #1;
    check("t6_clear", Clear, 1);
    step();
    check("t6_fetch", {Clear, Rd_Prog, Busy}, 3'b011);
    check("t6_pc", Prog_Addr, 0);
    check("t6_cnt", Clk_Count, 0);
    check("t6_acc_clr", acc, 0);
    step();
    check("t6_cnt1", Clk_Count, 1);
    step();
    check("t6_ignored", {Prog_Addr, Clk_Count}, {11'd1, 16'd2});
    Start = 0;
    run_to_halt("t6_halt");
    check("t6_cnt_end", Clk_Count, 8);
    check("t6_acc", acc, 7);
    // 3: LD 4; ADD 4; STO 5; HLT with mem[4]=10
    prog[0] = {5'd2, 11'd4};
    prog[1] = {5'd4, 11'd4};
    prog[2] = {5'd1, 11'd5};
    prog[3] = 16'd0;
    Start = 1;
    step();
    Start = 0;
    step();
    check("t3_ld_exec", {Rd, Wr, WrAcc, Addr}, {3'b100, 11'd4});
    step();
    check("t3_ld_mem", {Rd, Wr, WrAcc, SelA, Addr}, {5'b00110, 11'd4});
    step();
    step();
    check("t3_add_exec", {Rd, Addr}, {1'b1, 11'd4});
    step();
    check("t3_add_mem", {WrAcc, SelA, SelB, Op}, 5'b10011);
    step();
    step();
    check("t3_sto", {Rd, Wr, WrAcc, Addr}, {3'b010, 11'd5});
    run_to_halt("t3_halt");
    check("t3_cnt", Clk_Count, 10);
    check("t3_mem5", dmem[5], 20);
    check("t3_acc", acc, 20);
    // 4: reset during MEM of ADD
    prog[0] = {5'd4, 11'd4};
    Start = 1;
    step();
    Start = 0;
    step();
    step();
    check("t4_mem", WrAcc, 1);
    Reset = 0;
    #1;
    check("t4_no_wracc", {WrAcc, Clear, Busy}, 3'b010);
    step();
    Reset = 1;
    #1;
    check("t4_idle", {Busy, Halted, Clear}, 3'b001);
    check("t4_pc", Prog_Addr, 0);
    check("t4_cnt", Clk_Count, 0);
    // 5: undefined opcode at PC=2047 acts as NOP and PC wraps
    for (int i = 0; i < 2048; i++) prog[i] = 16'hF800;
    Start = 1;
    step();
    Start = 0;
    for (int n = 0; n < 5000 && !(Rd_Prog && Prog_Addr == 11'd2047); n++) step();
    check("t5_reach", {Rd_Prog, Prog_Addr}, {1'b1, 11'd2047});
    check("t5_cnt", Clk_Count, 4094);
    step();
    check("t5_nop", {Rd, Wr, WrAcc, Rd_Prog, Busy}, 5'b00001);
    step();
    check("t5_wrap", {Rd_Prog, Prog_Addr}, {1'b1, 11'd0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
